// File: rtl/des_link_ctrl.sv
// Link controller for the 32-bit deserializer: word-boundary hunt, sync lock
// and a one-entry valid/ready output buffer for non-sync words.
module des_link_ctrl #(
   parameter logic [31:0] SYNC_WORD  = 32'hA5A5_3C3C,
   parameter int          LOCK_COUNT = 4,
   parameter int          SLIP_LIMIT = 32
) (
   input  logic        clock,
   input  logic        rst,
   input  logic        link_en,
   input  logic        resync,
   input  logic [31:0] des_dout,
   output logic        des_enable,
   output logic        des_load,
   output logic [31:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        locked,
   output logic        sync_fail,
   output logic        overflow
);

   typedef enum logic [1:0] {IDLE, HUNT, CONFIRM, LOCKED} state_t;

   localparam logic [3:0] LC = 4'(LOCK_COUNT);
   localparam logic [5:0] SL = 6'(SLIP_LIMIT);

   state_t      state;
   state_t      state_nx;
   logic [4:0]  phase;
   logic        cmp;
   logic [3:0]  match_cnt;
   logic [5:0]  slip_cnt;
   logic [5:0]  slip_nx;
   logic        run;
   logic        hunting;
   logic        compare;
   logic        match;
   logic        act;
   logic        hit;
   logic        slip;
   logic        wr;
   logic        start;
   logic        cnt_done;

   assign run      = (state != IDLE);
   assign hunting  = (state == HUNT) || (state == CONFIRM);
   assign compare  = run && cmp;
   assign match    = (des_dout == SYNC_WORD);
   // link drop and resync both override whatever the compare says
   assign act      = compare && link_en && !resync;
   assign hit      = act && hunting && match;
   assign slip     = act && hunting && !match;
   assign wr       = act && (state == LOCKED) && !match;
   assign start    = (state == IDLE) && link_en;
   assign cnt_done = (match_cnt + 4'd1) == LC;
   assign slip_nx  = (slip_cnt == 6'd63) ? slip_cnt : slip_cnt + 6'd1;

   always_ff @(posedge clock or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (!link_en) begin
         state_nx = IDLE;
      end else begin
         unique case (state)
            IDLE:    state_nx = HUNT;
            HUNT:    if (hit) state_nx = (LC == 4'd1) ? LOCKED : CONFIRM;
                     else if (resync) state_nx = HUNT;
            CONFIRM: if (resync || slip) state_nx = HUNT;
                     else if (hit && cnt_done) state_nx = LOCKED;
            LOCKED:  if (resync) state_nx = HUNT;
            default: state_nx = IDLE;
         endcase
      end
   end

   always_comb begin
      des_enable = run;
      des_load   = run && (phase == 5'd31);
      locked     = (state == LOCKED);
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         phase     <= '0;
         cmp       <= 1'b0;
         match_cnt <= '0;
         slip_cnt  <= '0;
         sync_fail <= 1'b0;
         overflow  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         cmp <= des_load;
         // a slip holds phase at 0 one extra cycle, shifting the boundary
         if (!link_en || !run) phase <= '0;
         else if (!slip)       phase <= phase + 5'd1;

         if (!link_en || resync) begin
            match_cnt <= '0;
            slip_cnt  <= '0;
         end else if (hit) begin
            match_cnt <= (state == HUNT) ? 4'd1 : match_cnt + 4'd1;
         end else if (slip) begin
            match_cnt <= '0;
            slip_cnt  <= slip_nx;
         end

         if (start)                          sync_fail <= 1'b0;
         else if (slip && slip_nx >= SL)     sync_fail <= 1'b1;

         if (start)                                overflow <= 1'b0;
         else if (wr && out_valid && !out_ready)   overflow <= 1'b1;

         if (wr && (!out_valid || out_ready)) begin
            out_data  <= des_dout;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
